// File: rtl/jtag_master_shifter.sv
// JTAG master shifter: walks the target TAP through a reset sequence or an
// optional IR scan followed by an optional DR scan, generating TCK from clk.
module jtag_master_shifter #(
    parameter int unsigned TCK_DIV = 4,
    parameter int unsigned IR_LEN  = 4,
    parameter int unsigned DR_LEN  = 32
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              start,
    input  logic              tap_reset,
    input  logic              do_ir,
    input  logic              do_dr,
    input  logic [IR_LEN-1:0] ir_value,
    input  logic [DR_LEN-1:0] dr_out,
    input  logic              tdo,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    output logic [DR_LEN-1:0] dr_in,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SEG_MAX = (IR_LEN > DR_LEN) ? IR_LEN : DR_LEN;
    localparam int unsigned LEN_MAX = (SEG_MAX > 6) ? SEG_MAX : 6;
    localparam int unsigned CW      = $clog2(LEN_MAX + 1);
    localparam int unsigned PW      = $clog2(2 * TCK_DIV);
    localparam logic [PW-1:0] RISE_AT  = PW'(TCK_DIV - 1);
    localparam logic [PW-1:0] PRE_FALL = PW'(2 * TCK_DIV - 2);
    localparam logic [PW-1:0] FALL_AT  = PW'(2 * TCK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, TAP_RST, IR_HEAD, IR_SHIFT, IR_TAIL, DR_HEAD, DR_SHIFT, DR_TAIL, FINISH
    } state_t;

    state_t            state, state_next, first, follow;
    logic [PW-1:0]     phase, phase_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              tck_next, tms_next, tdi_next, busy_next, done_next;
    logic              latch, capture, last_bit, run_dr;
    logic [IR_LEN-1:0] ir_lat;
    logic [DR_LEN-1:0] dr_lat;

    // Index of the final TCK in each segment
    function automatic logic [CW-1:0] seg_last(input state_t s);
        case (s)
            TAP_RST:  return CW'(5);
            IR_HEAD:  return CW'(3);
            IR_SHIFT: return CW'(IR_LEN - 1);
            IR_TAIL:  return CW'(1);
            DR_HEAD:  return CW'(2);
            DR_SHIFT: return CW'(DR_LEN - 1);
            DR_TAIL:  return CW'(1);
            default:  return '0;
        endcase
    endfunction

    // TMS level for TCK i of segment s
    function automatic logic tms_bit(input state_t s, input logic [CW-1:0] i);
        case (s)
            TAP_RST:  return i < CW'(5);
            IR_HEAD:  return i < CW'(2);
            IR_SHIFT: return i == CW'(IR_LEN - 1);
            DR_SHIFT: return i == CW'(DR_LEN - 1);
            IR_TAIL, DR_HEAD, DR_TAIL: return i == '0;
            default:  return 1'b0;
        endcase
    endfunction

    // TDI level for TCK i of segment s; only the shift segments carry data
    function automatic logic tdi_bit(input state_t s, input logic [CW-1:0] i,
                                     input logic [IR_LEN-1:0] ir,
                                     input logic [DR_LEN-1:0] dr);
        logic [IR_LEN-1:0] ir_sh;
        logic [DR_LEN-1:0] dr_sh;
        ir_sh = ir >> i;
        dr_sh = dr >> i;
        case (s)
            IR_SHIFT: return ir_sh[0];
            DR_SHIFT: return dr_sh[0];
            default:  return 1'b0;
        endcase
    endfunction

    // Segment that follows s once its last TCK completes
    function automatic state_t next_seg(input state_t s, input logic with_dr);
        case (s)
            IR_HEAD:  return IR_SHIFT;
            IR_SHIFT: return IR_TAIL;
            IR_TAIL:  return with_dr ? DR_HEAD : FINISH;
            DR_HEAD:  return DR_SHIFT;
            DR_SHIFT: return DR_TAIL;
            default:  return FINISH;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) state <= IDLE;
        else           state <= state_next;
    end

    // Next state, TCK phase generation and next output levels
    always_comb begin
        state_next = state;
        phase_next = phase;
        cnt_next   = cnt;
        tck_next   = tck;
        tms_next   = tms;
        tdi_next   = tdi;
        busy_next  = busy;
        done_next  = 1'b0;
        latch      = 1'b0;
        capture    = 1'b0;
        first      = tap_reset ? TAP_RST : do_ir ? IR_HEAD : do_dr ? DR_HEAD : FINISH;
        follow     = next_seg(state, run_dr);
        last_bit   = (cnt == seg_last(state));
        case (state)
            IDLE: begin
                tck_next   = 1'b0;
                tms_next   = 1'b0;
                tdi_next   = 1'b0;
                phase_next = '0;
                cnt_next   = '0;
                if (start) begin
                    latch      = 1'b1;
                    busy_next  = 1'b1;
                    state_next = first;
                    tms_next   = tms_bit(first, '0);
                end
            end
            FINISH: begin
                tck_next   = 1'b0;
                tms_next   = 1'b0;
                tdi_next   = 1'b0;
                phase_next = '0;
                cnt_next   = '0;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                phase_next = phase + PW'(1);
                if (phase == RISE_AT) begin
                    tck_next = 1'b1;
                    capture  = (state == DR_SHIFT);
                end
                // Enter FINISH one clk early so its falling-TCK edge is the
                // same edge that raises done; no idle cycle before the pulse.
                if (phase == PRE_FALL && last_bit && follow == FINISH)
                    state_next = FINISH;
                if (phase == FALL_AT) begin
                    phase_next = '0;
                    tck_next   = 1'b0;
                    if (last_bit) begin
                        state_next = follow;
                        cnt_next   = '0;
                        tms_next   = tms_bit(follow, '0);
                        tdi_next   = tdi_bit(follow, '0, ir_lat, dr_lat);
                    end else begin
                        cnt_next = cnt + CW'(1);
                        tms_next = tms_bit(state, cnt + CW'(1));
                        tdi_next = tdi_bit(state, cnt + CW'(1), ir_lat, dr_lat);
                    end
                end
            end
        endcase
    end

    // Registered outputs, counters, request latch and DR capture
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            phase  <= '0;
            cnt    <= '0;
            tck    <= 1'b0;
            tms    <= 1'b1;
            tdi    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dr_in  <= '0;
            run_dr <= 1'b0;
            ir_lat <= '0;
            dr_lat <= '0;
        end else begin
            phase <= phase_next;
            cnt   <= cnt_next;
            tck   <= tck_next;
            tms   <= tms_next;
            tdi   <= tdi_next;
            busy  <= busy_next;
            done  <= done_next;
            if (latch) begin
                run_dr <= do_dr;
                ir_lat <= ir_value;
                dr_lat <= dr_out;
            end
            if (capture) dr_in <= {tdo, dr_in[DR_LEN-1:1]};
        end
    end

endmodule

// File: tb/tb_jtag_master_shifter.sv
// Self-checking bench for jtag_master_shifter with a behavioural target TAP.
module tb_jtag_master_shifter;

    localparam int unsigned TCK_DIV = 4;
    localparam int unsigned IR_LEN  = 4;
    localparam int unsigned DR_LEN  = 32;
    localparam logic [31:0] IDCODE  = 32'h100011D3;

    logic              clk = 1'b0;
    logic              notReset = 1'b0;
    logic              start = 1'b0;
    logic              tap_reset = 1'b0;
    logic              do_ir = 1'b0;
    logic              do_dr = 1'b0;
    logic [IR_LEN-1:0] ir_value = '0;
    logic [DR_LEN-1:0] dr_out = '0;
    logic              tdo;
    logic              tck, tms, tdi, busy, done;
    logic [DR_LEN-1:0] dr_in;

    jtag_master_shifter #(.TCK_DIV(TCK_DIV), .IR_LEN(IR_LEN), .DR_LEN(DR_LEN)) dut (
        .clk(clk), .notReset(notReset), .start(start), .tap_reset(tap_reset),
        .do_ir(do_ir), .do_dr(do_dr), .ir_value(ir_value), .dr_out(dr_out),
        .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi), .dr_in(dr_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Target TAP model
    typedef enum logic [3:0] {
        TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;
    tap_t              tap = TLR;
    logic [31:0]       tap_dr = '0;
    logic [IR_LEN-1:0] tap_irsh = '0;
    logic [IR_LEN-1:0] tap_ir = '0;
    logic              loopback = 1'b0;

    assign tdo = loopback ? tdi : tap_dr[0];

    always @(posedge tck) begin
        case (tap)
            CDR:  tap_dr <= IDCODE;
            SHDR: tap_dr <= {tdi, tap_dr[31:1]};
            SHIR: tap_irsh <= {tdi, tap_irsh[IR_LEN-1:1]};
            UIR:  tap_ir <= tap_irsh;
            default: ;
        endcase
        case (tap)
            TLR:  tap <= tms ? TLR  : RTI;
            RTI:  tap <= tms ? SDR  : RTI;
            SDR:  tap <= tms ? SIR  : CDR;
            CDR:  tap <= tms ? E1DR : SHDR;
            SHDR: tap <= tms ? E1DR : SHDR;
            E1DR: tap <= tms ? UDR  : PDR;
            PDR:  tap <= tms ? E2DR : PDR;
            E2DR: tap <= tms ? UDR  : SHDR;
            UDR:  tap <= tms ? SDR  : RTI;
            SIR:  tap <= tms ? TLR  : CIR;
            CIR:  tap <= tms ? E1IR : SHIR;
            SHIR: tap <= tms ? E1IR : SHIR;
            E1IR: tap <= tms ? UIR  : PIR;
            PIR:  tap <= tms ? E2IR : PIR;
            E2IR: tap <= tms ? UIR  : SHIR;
            default: tap <= tms ? SDR : RTI;
        endcase
    end

    typedef struct {
        string             name;
        int                tcks;
        logic [63:0]       tms_seq;
        logic [63:0]       tdi_seq;
        logic [31:0]       dr_val;
        int                lat;
        logic              chk_ir;
        logic [IR_LEN-1:0] ir;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          ntck = 0;
    logic [63:0] obs_tms = '0;
    logic [63:0] obs_tdi = '0;
    time         t_start = 0;
    logic        tck_q = 1'b0;
    logic [31:0] exp_hold = '0;

    // Monitor: record TMS/TDI at each TCK rise, score each done pulse
    always @(negedge clk) begin
        if (notReset) begin
            if (tck && !tck_q) begin
                if (ntck < 64) begin
                    obs_tms[ntck] = tms;
                    obs_tdi[ntck] = tdi;
                end
                ntck++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", done, 1'b0);
                end else begin
                    cur = sb.pop_front();
                    check_eq({cur.name, "_tcks"}, ntck, cur.tcks);
                    check_eq({cur.name, "_tms"}, obs_tms, cur.tms_seq);
                    check_eq({cur.name, "_tdi"}, obs_tdi, cur.tdi_seq);
                    check_eq({cur.name, "_dr_in"}, dr_in, cur.dr_val);
                    check_eq({cur.name, "_latency"}, int'(($time - t_start) / 10), cur.lat);
                    check_eq({cur.name, "_busy"}, busy, 1'b0);
                    check_eq({cur.name, "_tap_rti"}, tap, RTI);
                    if (cur.chk_ir) check_eq({cur.name, "_tap_ir"}, tap_ir, cur.ir);
                end
            end
        end
        tck_q = tck;
    end

    task automatic run_txn(input string name, input logic tr, input logic di, input logic dd,
                           input logic [IR_LEN-1:0] ir, input logic [31:0] dr,
                           input logic lb, input logic extra_start);
        exp_t e;
        int   n;
        n = 0;
        e.name    = name;
        e.tms_seq = '0;
        e.tdi_seq = '0;
        if (tr) begin
            for (int i = 0; i < 6; i++) begin
                e.tms_seq[n] = (i < 5);
                n++;
            end
        end else begin
            if (di) begin
                e.tms_seq[n] = 1'b1;
                e.tms_seq[n+1] = 1'b1;
                n += 4;
                for (int i = 0; i < IR_LEN; i++) begin
                    e.tdi_seq[n] = ir[i];
                    e.tms_seq[n] = (i == IR_LEN - 1);
                    n++;
                end
                e.tms_seq[n] = 1'b1;
                n += 2;
            end
            if (dd) begin
                e.tms_seq[n] = 1'b1;
                n += 3;
                for (int i = 0; i < DR_LEN; i++) begin
                    e.tdi_seq[n] = dr[i];
                    e.tms_seq[n] = (i == DR_LEN - 1);
                    n++;
                end
                e.tms_seq[n] = 1'b1;
                n += 2;
            end
        end
        if (!tr && dd) exp_hold = lb ? dr : IDCODE;
        e.tcks   = n;
        e.dr_val = exp_hold;
        e.lat    = (n == 0) ? 2 : 1 + 2 * TCK_DIV * n;
        e.chk_ir = di && !tr;
        e.ir     = ir;

        @(negedge clk);
        tap_reset = tr;
        do_ir     = di;
        do_dr     = dd;
        ir_value  = ir;
        dr_out    = dr;
        loopback  = lb;
        ntck      = 0;
        obs_tms   = '0;
        obs_tdi   = '0;
        t_start   = $time;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        tap_reset = 1'(($urandom_range(0, 1)));
        do_ir     = 1'(($urandom_range(0, 1)));
        do_dr     = 1'(($urandom_range(0, 1)));
        ir_value  = IR_LEN'($urandom);
        dr_out    = $urandom;
        if (extra_start) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            check_eq({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_tck", tck, 1'b0);
        check_eq("rst_tms", tms, 1'b1);
        check_eq("rst_tdi", tdi, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_dr_in", dr_in, 32'h0);
        notReset = 1'b1;
        @(negedge clk);
        check_eq("rel_tms", tms, 1'b0);

        run_txn("tap_rst", 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        run_txn("ir_only", 1'b0, 1'b1, 1'b0, 4'b0010, 32'h0, 1'b0, 1'b0);
        run_txn("ir_dr_idcode", 1'b0, 1'b1, 1'b1, 4'b0001, 32'h0, 1'b0, 1'b0);
        run_txn("dr_loop", 1'b0, 1'b0, 1'b1, 4'b0000, 32'hA5A5_0F0F, 1'b1, 1'b0);
        run_txn("ir_hold", 1'b0, 1'b1, 1'b0, 4'b1010, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_txn("busy_start", 1'b0, 1'b0, 1'b1, 4'b0000, 32'h1234_5678, 1'b1, 1'b1);
        run_txn("null", 1'b0, 1'b0, 1'b0, 4'b0110, 32'h0BAD_F00D, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_txn("rand", 1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                    IR_LEN'($urandom), $urandom, 1'b1, 1'b0);

        // Abort a DR scan during shift bit 10
        @(negedge clk);
        tap_reset = 1'b0;
        do_ir     = 1'b0;
        do_dr     = 1'b1;
        dr_out    = 32'hDEAD_BEEF;
        loopback  = 1'b0;
        ntck      = 0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000 && ntck < 14; k++) @(negedge clk);
        check_eq("abort_reach_bit10", ntck, 14);
        notReset = 1'b0;
        #1;
        check_eq("abort_tck", tck, 1'b0);
        check_eq("abort_tms", tms, 1'b1);
        check_eq("abort_tdi", tdi, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_dr_in", dr_in, 32'h0);
        exp_hold = '0;
        repeat (4) @(negedge clk);
        notReset = 1'b1;
        @(negedge clk);
        check_eq("abort_rel_tms", tms, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("abort_no_busy", busy, 1'b0);
        run_txn("tap_rst_after", 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
        run_txn("ir_dr_after", 1'b0, 1'b1, 1'b1, 4'b0001, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtag_master_shifter.md
JTAG_MASTER_SHIFTER -- requirements
Module: jtag_master_shifter

Interface
REQ-001 Parameter: TCK_DIV, 4, clk cycles per TCK half-period (>=2).
REQ-002 Parameter: IR_LEN, 4, instruction register length in bits.
REQ-003 Parameter: DR_LEN, 32, data register length in bits.
REQ-004 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-005 notReset  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to run one transaction.
REQ-007 tap_reset  input  1  with start: run a TAP reset sequence instead of a shift.
REQ-008 do_ir  input  1  with start: perform the IR scan.
REQ-009 do_dr  input  1  with start: perform the DR scan after the optional IR scan.
REQ-010 ir_value  input  IR_LEN  instruction shifted out, LSB first.
REQ-011 dr_out  input  DR_LEN  data shifted out, LSB first.
REQ-012 tdo  input  1  serial data from the target TAP.
REQ-013 tck  output  1  JTAG test clock.
REQ-014 tms  output  1  JTAG mode select.
REQ-015 tdi  output  1  serial data to the target TAP.
REQ-016 dr_in  output  DR_LEN  data captured from tdo during the DR scan.
REQ-017 busy  output  1  high while a transaction is in progress.
REQ-018 done  output  1  one-cycle pulse at transaction end.

Function
REQ-019 start is accepted only while busy=0; tap_reset, do_ir, do_dr, ir_value and dr_out are latched on acceptance; start while busy=1 is ignored.
REQ-020 busy rises on the clk edge following accepted start.
REQ-021 TCK period = 2*TCK_DIV clk cycles: low half, then high half; tck idles low.
REQ-022 tms/tdi change only on the clk edge where tck goes low; tdo is sampled on the clk edge where tck goes high.
REQ-023 States: IDLE, TAP_RST, IR_HEAD, IR_SHIFT, IR_TAIL, DR_HEAD, DR_SHIFT, DR_TAIL, FINISH.
REQ-024 TAP_RST: 5 TCKs with tms=1, then 1 TCK with tms=0 (target ends in Run-Test/Idle); tap_reset overrides do_ir/do_dr.
REQ-025 IR_HEAD: 4 TCKs with tms=1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
REQ-026 IR_SHIFT: IR_LEN TCKs, tdi=ir_value bit i on TCK i; tms=0 except tms=1 on the last bit.
REQ-027 IR_TAIL: 2 TCKs with tms=1,0 (Update-IR, Run-Test/Idle).
REQ-028 DR_HEAD: 3 TCKs with tms=1,0,0 (Select-DR, Capture-DR, Shift-DR).
REQ-029 DR_SHIFT: DR_LEN TCKs, tdi=dr_out bit i; tms=1 on the last bit only; each sampled tdo shifts in as dr_in <= {tdo, dr_in[DR_LEN-1:1]}.
REQ-030 DR_TAIL: 2 TCKs with tms=1,0.
REQ-031 The IR scan runs before the DR scan when both are selected; an unselected scan is skipped entirely.
REQ-032 do_ir=0, do_dr=0, tap_reset=0: no TCK edges; go directly to FINISH.
REQ-033 FINISH: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
REQ-034 In IDLE, tms=0 and tdi=0.
REQ-035 dr_in updates only during DR_SHIFT and holds its value otherwise, including across IR-only transactions.
REQ-036 Bit and TCK counters are sized to cover max(IR_LEN, DR_LEN) and never wrap mid-scan.

Reset
REQ-037 When notReset=0, asynchronously: state=IDLE, tck=0, tms=1, tdi=0, busy=0, done=0, dr_in=0, counters=0.
REQ-038 Reset mid-transaction aborts the transaction with no done pulse; the target TAP state is then undefined until a tap_reset transaction completes.
REQ-039 After notReset rises, tms returns to 0 on the first clk edge.

Verification
REQ-040 start, tap_reset=1, TCK_DIV=4 -> 6 TCK pulses, tms=1,1,1,1,1,0; done 48 clks after busy rises.
REQ-041 start, do_ir=1, ir_value=4'b0010 -> 10 TCKs; tdi during IR_SHIFT = 0,1,0,0; tms=1 only on TCKs 1, 2, 8 and 9.
REQ-042 start, do_ir=1, do_dr=1, ir_value=4'b0001, dr_out=0, TAP model returns 32'h100011D3 -> 47 TCKs total; dr_in=32'h100011D3 at done.
REQ-043 start, do_dr=1, dr_out=32'hA5A5_0F0F, loopback tdo=tdi -> dr_in=32'hA5A5_0F0F; no IR TCKs.
REQ-044 Second start pulse while busy=1 -> ignored; exactly one done pulse; start with all selects 0 -> done 2 clks after start, no tck activity.
REQ-045 notReset low during DR_SHIFT bit 10 -> outputs take reset values immediately; no done; a following tap_reset transaction completes normally.
